// File: rtl/wavetable_mem.sv
// wavetable_mem: multi-voice wavetable RAM, one write port, round-robin shared read port.
// Define WT_INTERP_EN for linear interpolation between adjacent samples (two reads per grant).
module wavetable_mem #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 9,
    parameter int N_VOICES = 4,
    parameter int FRAC_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [N_VOICES-1:0]          req_valid,
    input  logic [N_VOICES*ADDR_W-1:0]   req_addr,
    input  logic [N_VOICES*FRAC_W-1:0]   req_frac,
    output logic [N_VOICES-1:0]          req_ack,
    output logic [N_VOICES-1:0]          resp_valid,
    output logic [N_VOICES*DATA_W-1:0]   resp_data
);
    localparam int PTR_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

    logic [DATA_W-1:0]          mem [2**ADDR_W];
    logic [DATA_W-1:0]          rd_q;
    logic [ADDR_W-1:0]          rd_addr;
    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d, gnt_id, idx, id_q, id_d;
    logic                       gnt_v, busy, st1_v_q, st1_v_d, fin_v;
    logic [DATA_W-1:0]          fin_data;
    logic [N_VOICES-1:0]        resp_valid_q, resp_valid_d;
    logic [N_VOICES*DATA_W-1:0] resp_data_q, resp_data_d;

    always_comb begin
        req_ack = '0;
        gnt_v   = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = 0; k < N_VOICES; k++) begin
            idx = PTR_W'((int'(rr_ptr_q) + k) % N_VOICES);
            if (!gnt_v && !busy && rst_n && req_valid[idx]) begin
                gnt_v  = 1'b1;
                gnt_id = idx;
            end
        end
        if (gnt_v) req_ack[gnt_id] = 1'b1;
        rr_ptr_d = !gnt_v ? rr_ptr_q : (int'(gnt_id) == N_VOICES - 1) ? '0 : gnt_id + 1'b1;
    end

`ifdef WT_INTERP_EN
    logic                      st2_v_q, st2_v_d;
    logic [ADDR_W-1:0]         a1_q, a1_d;
    logic [FRAC_W-1:0]         frac_q, frac_d;
    logic [DATA_W-1:0]         s0_q, s0_d;
    logic signed [DATA_W:0]    diff;
    logic signed [DATA_W+FRAC_W:0] prod;

    // The cycle after a grant the RAM port is reserved for the second sample.
    assign busy = st1_v_q;

    always_comb begin
        st1_v_d  = gnt_v;
        st2_v_d  = st1_v_q;
        id_d     = gnt_v ? gnt_id : id_q;
        a1_d     = gnt_v ? req_addr[gnt_id*ADDR_W +: ADDR_W] + ADDR_W'(1) : a1_q;
        frac_d   = gnt_v ? req_frac[gnt_id*FRAC_W +: FRAC_W] : frac_q;
        s0_d     = st1_v_q ? rd_q : s0_q;
        rd_addr  = st1_v_q ? a1_q : req_addr[gnt_id*ADDR_W +: ADDR_W];
        diff     = $signed({1'b0, rd_q}) - $signed({1'b0, s0_q});
        prod     = $signed({{FRAC_W{diff[DATA_W]}}, diff}) * $signed({{(DATA_W+1){1'b0}}, frac_q});
        fin_v    = st2_v_q;
        fin_data = s0_q + DATA_W'(prod >>> FRAC_W);
    end
`else
    logic unused_frac;

    assign busy        = 1'b0;
    assign unused_frac = ^req_frac;

    always_comb begin
        st1_v_d  = gnt_v;
        id_d     = gnt_v ? gnt_id : id_q;
        rd_addr  = req_addr[gnt_id*ADDR_W +: ADDR_W];
        fin_v    = st1_v_q;
        fin_data = rd_q;
    end
`endif

    always_comb begin
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        if (fin_v) begin
            resp_valid_d[id_q]                   = 1'b1;
            resp_data_d[id_q*DATA_W +: DATA_W]   = fin_data;
        end
    end

    // Read-before-write on the same edge gives old data for same-cycle collisions.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            id_q         <= '0;
            st1_v_q      <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
`ifdef WT_INTERP_EN
            st2_v_q      <= 1'b0;
            a1_q         <= '0;
            frac_q       <= '0;
            s0_q         <= '0;
`endif
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            st1_v_q      <= st1_v_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
`ifdef WT_INTERP_EN
            st2_v_q      <= st2_v_d;
            a1_q         <= a1_d;
            frac_q       <= frac_d;
            s0_q         <= s0_d;
`endif
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
endmodule

// File: tb/tb_wavetable_mem.sv
// tb_wavetable_mem: directed and randomized checks of wavetable_mem against a cycle-level
// behavioural model (table array, round-robin search, queue of due responses).
module tb_wavetable_mem;
    localparam int DW = 16, AW = 9, NV = 4, FW = 4;
`ifdef WT_INTERP_EN
    localparam int LAT = 3, GAP = 2;
`else
    localparam int LAT = 2, GAP = 1;
`endif

    logic              clk = 1'b0, rst_n, wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [NV-1:0]     req_valid, req_ack, resp_valid, ack_s;
    logic [NV*AW-1:0]  req_addr;
    logic [NV*FW-1:0]  req_frac;
    logic [NV*DW-1:0]  resp_data;
    int n_checks = 0, n_errors = 0;

    wavetable_mem #(.DATA_W(DW), .ADDR_W(AW), .N_VOICES(NV), .FRAC_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .req_valid(req_valid), .req_addr(req_addr), .req_frac(req_frac),
        .req_ack(req_ack), .resp_valid(resp_valid), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int cyc; int v; logic [DW-1:0] d; } rsp_t;
    rsp_t          q[$];
    logic [DW-1:0] m_mem [1<<AW];
    logic [DW-1:0] m_data [NV];
    int            m_rr = 0, cyc = 0;
    bit            m_busy = 0;
`ifdef WT_INTERP_EN
    bit            p_v = 0;
    int            p_voice, p_addr, p_frac;
    logic [DW-1:0] p_s0;

    function automatic logic [DW-1:0] lerp(input logic [DW-1:0] s0, input logic [DW-1:0] s1, input int f);
        int p, den, fl;
        den = 1 << FW;
        p   = (int'(s1) - int'(s0)) * f;
        fl  = (p >= 0) ? p / den : -((-p + den - 1) / den);
        return DW'(int'(s0) + fl);
    endfunction
`endif

    initial foreach (m_data[i]) m_data[i] = '0;

    always @(negedge clk) begin
        logic [NV-1:0]    e_v, e_ack;
        logic [NV*DW-1:0] e_pack;
        int g, a;
        cyc++;
        e_v = '0; e_ack = '0; g = -1;
        if (!rst_n) begin
            q.delete();
            m_rr = 0; m_busy = 0;
`ifdef WT_INTERP_EN
            p_v = 0;
`endif
            foreach (m_data[i]) m_data[i] = '0;
        end else begin
            while (q.size() > 0 && q[0].cyc == cyc) begin
                e_v[q[0].v] = 1'b1;
                m_data[q[0].v] = q[0].d;
                void'(q.pop_front());
            end
`ifdef WT_INTERP_EN
            if (p_v) begin
                q.push_back('{cyc + 2, p_voice, lerp(p_s0, m_mem[(p_addr + 1) % (1 << AW)], p_frac)});
                p_v = 0;
            end
`endif
            if (!m_busy)
                for (int k = 0; k < NV; k++)
                    if (g < 0 && req_valid[(m_rr + k) % NV]) g = (m_rr + k) % NV;
            if (g >= 0) begin
                e_ack[g] = 1'b1;
                a = int'(req_addr[g*AW +: AW]);
                m_rr = (g + 1) % NV;
`ifdef WT_INTERP_EN
                p_v = 1; p_voice = g; p_addr = a; p_frac = int'(req_frac[g*FW +: FW]); p_s0 = m_mem[a];
`else
                q.push_back('{cyc + 2, g, m_mem[a]});
`endif
            end
`ifdef WT_INTERP_EN
            m_busy = (g >= 0);
`endif
        end
        for (int i = 0; i < NV; i++) e_pack[i*DW +: DW] = m_data[i];
        chk("req_ack", req_ack, e_ack);
        chk("resp_valid", resp_valid, e_v);
        chk("resp_data", resp_data, e_pack);
        if (wr_en === 1'b1) m_mem[wr_addr] = wr_data;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_ack(output int w);
        w = 0;
        @(negedge clk);
        while (req_ack == '0 && w < 8) begin step(); w++; @(negedge clk); end
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(d);
        step();
        wr_en = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 3);
        return (r == 0) ? AW'(511) : (r == 1) ? AW'(510) : AW'($urandom_range(0, 15));
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = '0; req_addr = '0; req_frac = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < (1 << AW); k++) begin
            wr_en = 1'b1; wr_addr = AW'(k); wr_data = DW'(k * 16);
            step();
        end
        wr_en = 1'b0;

        // single voice lookup on the ramp
        req_valid = 4'b0001; req_addr[0 +: AW] = 9'h005;
        @(negedge clk); chk("t1_ack", req_ack, 4'b0001);
        step(); req_valid = '0;
        @(negedge clk); chk("t1_early", resp_valid, 4'b0000);
        repeat (LAT - 1) step();
        @(negedge clk);
        chk("t1_valid", resp_valid, 4'b0001);
        chk("t1_data", resp_data, 64'h0000_0000_0000_0050);
        step();

        // all voices from reset: grants 0,1,2,3
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int v = 0; v < NV; v++) req_addr[v*AW +: AW] = AW'(v + 1);
        req_valid = 4'b1111;
        for (int k = 0; k < NV; k++) begin
            wait_ack(w);
            chk("t2_ack", req_ack, 64'(1) << k);
            if (k > 0) chk("t2_gap", w + 1, GAP);
            step(); req_valid[k] = 1'b0;
        end
        repeat (4) step();
        @(negedge clk); chk("t2_data", resp_data, 64'h0040_0030_0020_0010);

        // same-cycle write/read collision
        step();
        wr(7, 16'h1111);
        wr_en = 1'b1; wr_addr = 9'd7; wr_data = 16'h2222;
        req_valid = 4'b0001; req_addr[0 +: AW] = 9'd7;
        @(negedge clk); chk("t3_ack0", req_ack, 4'b0001);
        step(); wr_en = 1'b0; req_valid = 4'b0010; req_addr[AW +: AW] = 9'd7;
        wait_ack(w); chk("t3_ack1", req_ack, 4'b0010);
        step(); req_valid = '0;
        repeat (5) step();
        @(negedge clk);
        chk("t3_old", resp_data[0 +: DW], 16'h1111);
        chk("t3_new", resp_data[DW +: DW], 16'h2222);

        // reset right after a grant discards the read
        step();
        req_valid = 4'b0100; req_addr[2*AW +: AW] = 9'd3;
        @(negedge clk); chk("t4_ack", req_ack, 4'b0100);
        step(); req_valid = '0; rst_n = 1'b0;
        @(negedge clk); chk("t4_rst_valid", resp_valid, 4'b0000);
        step(); rst_n = 1'b1;
        repeat (3) begin @(negedge clk); chk("t4_no_resp", resp_valid, 4'b0000); step(); end
        @(negedge clk); chk("t4_data0", resp_data, 64'h0);
        step(); req_valid = 4'b1111;
        @(negedge clk); chk("t4_rr0", req_ack, 4'b0001);
        step(); req_valid = '0;

`ifdef WT_INTERP_EN
        // top-of-table wrap and grant spacing
        wr(9'h1FF, 16'h8000); wr(0, 0);
        req_addr[0 +: AW] = 9'h1FF; req_frac[0 +: FW] = 4'h0;
        req_addr[AW +: AW] = 9'h1FF; req_frac[FW +: FW] = 4'h4;
        req_valid = 4'b0011;
        @(negedge clk); chk("t5_ack1", req_ack, 4'b0010);
        step(); req_valid[1] = 1'b0;
        @(negedge clk); chk("t5_hold", req_ack, 4'b0000);
        step();
        @(negedge clk); chk("t5_ack0", req_ack, 4'b0001);
        step(); req_valid = '0;
        @(negedge clk);
        chk("t5_valid", resp_valid, 4'b0010);
        chk("t5_wrap", resp_data[DW +: DW], 16'h6000);
        step(); step();
        @(negedge clk); chk("t5_s0", resp_data[0 +: DW], 16'h8000);
        // arithmetic shift rounds toward minus infinity
        step();
        wr(9'h020, 3); wr(9'h021, 0);
        req_valid = 4'b0100; req_addr[2*AW +: AW] = 9'h020; req_frac[2*FW +: FW] = 4'hF;
        @(negedge clk); chk("t6_ack", req_ack, 4'b0100);
        step(); req_valid = '0;
        repeat (2) step();
        @(negedge clk);
        chk("t6_valid", resp_valid, 4'b0100);
        chk("t6_floor", resp_data[2*DW +: DW], 16'h0000);
        step();
`endif

        // randomized traffic with occasional resets
        for (int v = 0; v < NV; v++) wr(v * 3, $urandom);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); ack_s = req_ack;
            step();
            rst_n = ($urandom_range(0, 499) != 0);
            for (int v = 0; v < NV; v++) begin
                if (ack_s[v] || !req_valid[v]) begin
                    req_valid[v] = ($urandom_range(0, 1) == 1);
                    req_addr[v*AW +: AW] = rand_addr();
                    req_frac[v*FW +: FW] = FW'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[v] = 1'b0;
                end
            end
            wr_en = ($urandom_range(0, 2) == 0);
            wr_addr = rand_addr();
            wr_data = DW'($urandom);
        end
        rst_n = 1'b1; req_valid = '0; wr_en = 1'b0;
        repeat (6) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
